// File: rtl/acc_mod2nm1_pkg.sv
// Shared types and the behavioural end-around-carry reference for the
// mod (2^WIDTH - 1) stream accumulator.
package acc_mod2nm1_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_e;

    // Double-zero end-around add: a sum equal to the modulus stays all-ones.
    function automatic logic [63:0] mod_add_ref(input logic [63:0] a,
                                                input logic [63:0] b,
                                                input int unsigned w);
        logic [63:0] m;
        logic [64:0] s;
        m = (64'd1 << w) - 64'd1;
        s = {1'b0, a & m} + {1'b0, b & m};
        if (s > {1'b0, m}) s = s - {1'b0, m};
        return s[63:0];
    endfunction

endpackage

// File: rtl/acc_mod2nm1_stream_eac.sv
// Combinational WIDTH-bit end-around-carry adder; SPEED picks the carry
// prefix network (0 serial, 1 Brent-Kung, 2 Sklansky).
module eac_add_cell #(
    parameter int WIDTH = 8,
    parameter int SPEED = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);
    localparam int LVL = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] grpG;
    logic [WIDTH-1:0] grpP;
    logic [WIDTH-1:0] carry;
    logic             carryOut;

    always_comb begin
        gen  = a_i & b_i;
        prop = a_i ^ b_i;
        grpG = gen;
        grpP = prop;
        if (SPEED == 0) begin
            for (int i = 1; i < WIDTH; i++) begin
                grpG[i] = grpG[i] | (grpP[i] & grpG[i-1]);
                grpP[i] = grpP[i] & grpP[i-1];
            end
        end else if (SPEED == 1) begin
            for (int l = 0; l < LVL; l++) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (((i + 1) % (2 << l)) == 0 && (i - (1 << l)) >= 0) begin
                        grpG[i] = grpG[i] | (grpP[i] & grpG[i - (1 << l)]);
                        grpP[i] = grpP[i] & grpP[i - (1 << l)];
                    end
                end
            end
            // Down-sweep fills the odd-span nodes from completed prefixes.
            for (int l = LVL - 1; l >= 0; l--) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (((i + 1) % (2 << l)) == (1 << l) && i >= (2 << l)) begin
                        grpG[i] = grpG[i] | (grpP[i] & grpG[i - (1 << l)]);
                        grpP[i] = grpP[i] & grpP[i - (1 << l)];
                    end
                end
            end
        end else begin
            for (int l = 0; l < LVL; l++) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (((i >> l) & 1) == 1) begin
                        grpG[i] = grpG[i] | (grpP[i] & grpG[((i >> l) << l) - 1]);
                        grpP[i] = grpP[i] & grpP[((i >> l) << l) - 1];
                    end
                end
            end
        end
        carryOut = grpG[WIDTH-1];
        carry    = '0;
        carry[0] = carryOut;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = grpG[i-1] | (grpP[i-1] & carryOut);
        end
        sum_o = prop ^ carry;
    end

endmodule

// File: rtl/acc_mod2nm1_stream.sv
// Framed multi-lane one's-complement accumulator with a valid/ready result.
// Define ACC_MOD2NM1_SINGLE_ZERO_EN to present an all-ones sum as zero.
module acc_mod2nm1_stream #(
    parameter int WIDTH = 8,
    parameter int LANES = 2,
    parameter int SPEED = 0,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [LANES*WIDTH-1:0] in_data_i,
    input  logic [LANES-1:0]       in_mask_i,
    input  logic                   in_last_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [WIDTH-1:0]       out_sum_o,
    output logic [CNT_W-1:0]       out_beats_o
);
    import acc_mod2nm1_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             beatFire;
    logic [WIDTH-1:0] chain [LANES+1];
    logic [WIDTH-1:0] laneOp [LANES];

    // A new frame folds its first beat onto zero rather than the stale acc.
    assign chain[0] = (state_q == IDLE) ? '0 : acc_q;

    for (genvar k = 0; k < LANES; k++) begin : gLane
        assign laneOp[k] = in_mask_i[k] ? in_data_i[k*WIDTH +: WIDTH] : '0;
        eac_add_cell #(.WIDTH(WIDTH), .SPEED(SPEED)) uAdd (
            .a_i  (chain[k]),
            .b_i  (laneOp[k]),
            .sum_o(chain[k+1])
        );
    end

    assign beatFire = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            beats_q <= beats_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        beats_d = beats_q;
        case (state_q)
            IDLE: begin
                if (beatFire) begin
                    acc_d   = chain[LANES];
                    beats_d = CNT_W'(1);
                    state_d = in_last_i ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beatFire) begin
                    acc_d   = chain[LANES];
                    beats_d = (&beats_q) ? beats_q : beats_q + CNT_W'(1);
                    if (in_last_i) state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    beats_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE, ACCUM: in_ready_o  = !rst_i;
            HOLD:        out_valid_o = 1'b1;
            default: ;
        endcase
    end

`ifdef ACC_MOD2NM1_SINGLE_ZERO_EN
    assign out_sum_o = (&acc_q) ? '0 : acc_q;
`else
    assign out_sum_o = acc_q;
`endif
    assign out_beats_o = beats_q;

endmodule

// File: tb/tb_acc_mod2nm1_stream.sv
// Randomised self-checking bench for acc_mod2nm1_stream (WIDTH=8, LANES=2),
// with a second CNT_W=2 instance sharing the stimulus to exercise saturation.
module tb_acc_mod2nm1_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [15:0] inData;
    logic [1:0]  inMask;
    logic        inLast;
    logic        outReady;
    logic        inReady, outValid;
    logic [7:0]  outSum;
    logic [15:0] outBeats;
    logic        inReady2, outValid2;
    logic [7:0]  outSum2;
    logic [1:0]  outBeats2;

    int total = 0;
    int bad   = 0;

`ifdef ACC_MOD2NM1_SINGLE_ZERO_EN
    localparam logic [7:0] ALL_ONES_VIEW = 8'h00;
`else
    localparam logic [7:0] ALL_ONES_VIEW = 8'hFF;
`endif

    always #5 clk = ~clk;

    acc_mod2nm1_stream #(.WIDTH(8), .LANES(2), .SPEED(0), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady),
        .in_data_i(inData), .in_mask_i(inMask), .in_last_i(inLast),
        .out_valid_o(outValid), .out_ready_i(outReady),
        .out_sum_o(outSum), .out_beats_o(outBeats)
    );

    acc_mod2nm1_stream #(.WIDTH(8), .LANES(2), .SPEED(2), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady2),
        .in_data_i(inData), .in_mask_i(inMask), .in_last_i(inLast),
        .out_valid_o(outValid2), .out_ready_i(outReady),
        .out_sum_o(outSum2), .out_beats_o(outBeats2)
    );

    // Residue of the plain integer total: zero only if nothing nonzero was added.
    function automatic logic [7:0] modelSum(input longint t);
        longint r;
        if (t == 0) return 8'h00;
        r = ((t - 1) % 255) + 1;
        if (r == 255) return ALL_ONES_VIEW;
        return 8'(r);
    endfunction

    function automatic longint beatTotal(input logic [15:0] d, input logic [1:0] m);
        longint s;
        s = 0;
        if (m[0]) s += longint'(d[7:0]);
        if (m[1]) s += longint'(d[15:8]);
        return s;
    endfunction

    // Drives one beat for one clock; caller guarantees the DUT is accepting.
    task automatic putBeat(input logic [15:0] d, input logic [1:0] m, input logic l);
        inValid = 1'b1; inData = d; inMask = m; inLast = l;
        @(posedge clk); #1;
        inValid = 1'b0; inData = $urandom; inMask = 2'($urandom); inLast = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; inValid = 1'b1; inData = 16'hA5A5; inMask = 2'b11; inLast = 1'b0;
        outReady = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        total++; if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=0", inReady); end
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", outValid); end
        total++; if (outSum !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_sum got=%h want=00", outSum); end
        total++; if (outBeats !== 16'd0) begin bad++; $display("[TB] FAIL reset_out_beats got=%0d want=0", outBeats); end
        inValid = 1'b0; rst = 1'b0; #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL idle_in_ready got=%b want=1", inReady); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        outReady = 1'b1;
        putBeat(16'h3412, 2'b11, 1'b0);
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_valid got=%b want=0", outValid); end
        putBeat(16'h0FF0, 2'b11, 1'b1);
        total++; if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid got=%b want=1", outValid); end
        total++; if (outSum !== 8'h46) begin bad++; $display("[TB] FAIL basic_sum got=%h want=46", outSum); end
        total++; if (outBeats !== 16'd2) begin bad++; $display("[TB] FAIL basic_beats got=%0d want=2", outBeats); end
        total++; if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL basic_hold_ready got=%b want=0", inReady); end
        @(posedge clk); #1;
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL basic_valid_drop got=%b want=0", outValid); end
        total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL basic_ready_back got=%b want=1", inReady); end
    endtask

    task automatic test_end_around();
        outReady = 1'b1;
        putBeat(16'h01FF, 2'b11, 1'b1);
        total++; if (outSum !== 8'h01) begin bad++; $display("[TB] FAIL eac_carry got=%h want=01", outSum); end
        total++; if (outBeats !== 16'd1) begin bad++; $display("[TB] FAIL eac_beats got=%0d want=1", outBeats); end
        @(posedge clk); #1;
        putBeat(16'h0FF0, 2'b11, 1'b1);
        total++; if (outSum !== ALL_ONES_VIEW) begin bad++; $display("[TB] FAIL eac_all_ones got=%h want=%h", outSum, ALL_ONES_VIEW); end
        @(posedge clk); #1;
    endtask

    task automatic test_masks();
        outReady = 1'b1;
        putBeat(16'hFFFF, 2'b11, 1'b1);
        total++; if (outSum !== ALL_ONES_VIEW) begin bad++; $display("[TB] FAIL mask_ff_ff got=%h want=%h", outSum, ALL_ONES_VIEW); end
        @(posedge clk); #1;
        putBeat(16'hAA55, 2'b10, 1'b1);
        total++; if (outSum !== 8'hAA) begin bad++; $display("[TB] FAIL mask_upper got=%h want=aa", outSum); end
        @(posedge clk); #1;
        putBeat(16'h1234, 2'b00, 1'b0);
        putBeat(16'h0403, 2'b11, 1'b1);
        total++; if (outSum !== 8'h07) begin bad++; $display("[TB] FAIL mask_none_sum got=%h want=07", outSum); end
        total++; if (outBeats !== 16'd2) begin bad++; $display("[TB] FAIL mask_none_beats got=%0d want=2", outBeats); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        outReady = 1'b0;
        putBeat(16'h2211, 2'b11, 1'b1);
        for (int c = 0; c < 5; c++) begin
            inValid = 1'b1; inData = 16'($urandom); inMask = 2'b11; inLast = 1'b1;
            #1;
            total++; if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready c=%0d got=%b want=0", c, inReady); end
            @(posedge clk); #1;
            total++; if (outValid !== 1'b1 || outSum !== 8'h33 || outBeats !== 16'd1) begin
                bad++; $display("[TB] FAIL bp_stable c=%0d got=%b/%h/%0d want=1/33/1", c, outValid, outSum, outBeats);
            end
        end
        inValid = 1'b0; outReady = 1'b1;
        @(posedge clk); #1;
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release got=%b want=0", outValid); end
        putBeat(16'h0605, 2'b11, 1'b1);
        total++; if (outSum !== 8'h0B || outBeats !== 16'd1) begin
            bad++; $display("[TB] FAIL bp_next_frame got=%h/%0d want=0b/1", outSum, outBeats);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        outReady = 1'b1;
        for (int b = 0; b < 3; b++) putBeat(16'h4321, 2'b11, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (outValid !== 1'b0 || outSum !== 8'h00 || outBeats !== 16'd0) begin
            bad++; $display("[TB] FAIL midrst_regs got=%b/%h/%0d want=0/00/0", outValid, outSum, outBeats);
        end
        total++; if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ready got=%b want=0", inReady); end
        rst = 1'b0;
        putBeat(16'h0201, 2'b11, 1'b1);
        total++; if (outSum !== 8'h03 || outBeats !== 16'd1) begin
            bad++; $display("[TB] FAIL midrst_after got=%h/%0d want=03/1", outSum, outBeats);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int f = 0; f < 25; f++) begin
            int     n;
            int     hold;
            longint t;
            logic [15:0] d;
            logic [1:0]  m;
            n    = $urandom_range(1, 64);
            hold = $urandom_range(0, 3);
            t    = 0;
            outReady = 1'b0;
            for (int b = 0; b < n; b++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                d = 16'($urandom);
                m = 2'($urandom_range(0, 3));
                t += beatTotal(d, m);
                putBeat(d, m, b == n - 1);
            end
            repeat (hold) begin @(posedge clk); #1; end
            total++; if (outValid !== 1'b1 || outSum !== modelSum(t) || outBeats !== 16'(n)) begin
                bad++; $display("[TB] FAIL rand f=%0d got=%b/%h/%0d want=1/%h/%0d", f, outValid, outSum, outBeats, modelSum(t), n);
            end
            total++; if (outValid2 !== 1'b1 || outSum2 !== modelSum(t) || outBeats2 !== 2'((n > 3) ? 3 : n)) begin
                bad++; $display("[TB] FAIL rand_sat f=%0d got=%b/%h/%0d want=1/%h/%0d", f, outValid2, outSum2, outBeats2, modelSum(t), (n > 3) ? 3 : n);
            end
            outReady = 1'b1;
            @(posedge clk); #1;
            total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL rand_drop f=%0d got=%b want=0", f, outValid); end
        end
    endtask

    task automatic test_saturation();
        outReady = 1'b1;
        for (int b = 0; b < 5; b++) putBeat(16'h8080, 2'b11, b == 4);
        total++; if (outBeats2 !== 2'd3) begin bad++; $display("[TB] FAIL sat_beats got=%0d want=3", outBeats2); end
        total++; if (outSum2 !== 8'h05) begin bad++; $display("[TB] FAIL sat_sum got=%h want=05", outSum2); end
        total++; if (outBeats !== 16'd5) begin bad++; $display("[TB] FAIL wide_beats got=%0d want=5", outBeats); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_end_around();
        test_masks();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
